// File: rtl/ula_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequencer_pkg
// Purpose  : Shared definitions for the ALU sequencer. These are the opcode
//            values, the ALU operation codes (tula) and the sequencer state
//            encoding. The assembler and the test ROMs use the same values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ula_sequencer_pkg;

  // Upper nibble of an instruction; bit 7 set means an ALU operation.
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDX = 4'b0001;
  localparam logic [3:0] OP_LDY = 4'b0010;
  localparam logic [3:0] OP_MOV = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JF  = 4'b0101;
  localparam logic [3:0] OP_HLT = 4'b0110;

  // ALU operation codes driven on tula.
  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_NEG = 3'b010;
  localparam logic [2:0] ULA_EQ  = 3'b011;
  localparam logic [2:0] ULA_GT  = 3'b100;
  localparam logic [2:0] ULA_LT  = 3'b101;
  localparam logic [2:0] ULA_AND = 3'b110;
  localparam logic [2:0] ULA_XOR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Compare operations update the flag instead of writing X.
  function automatic logic is_cmp(input logic [2:0] ttt);
    return (ttt == ULA_EQ) || (ttt == ULA_GT) || (ttt == ULA_LT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : ula_seq_decode
// Purpose  : Combinational decode of the instruction register into
//            write-enables and control-flow strobes.
// Ports    : i_ir          - instruction register {opcode, imm}
//            o_wr_x        - X is written in EXEC
//            o_x_from_alu  - X source is the ALU result (otherwise imm)
//            o_wr_y        - Y is written in EXEC
//            o_y_from_x    - Y source is X (MOV), otherwise imm
//            o_wr_flag     - flag latches ALU status in EXEC
//            o_is_jmp      - unconditional jump in WB
//            o_is_jf       - jump-if-flag in WB
//            o_is_hlt      - halt after WB
// Revision : 1.0 - initial release
// ============================================================================
module ula_seq_decode (
  input  logic [7:0] i_ir,
  output logic       o_wr_x,
  output logic       o_x_from_alu,
  output logic       o_wr_y,
  output logic       o_y_from_x,
  output logic       o_wr_flag,
  output logic       o_is_jmp,
  output logic       o_is_jf,
  output logic       o_is_hlt
);
  import ula_sequencer_pkg::*;

  logic [3:0] w_op;
  logic       w_is_alu;
  logic       w_alu_cmp;

  assign w_op      = i_ir[7:4];
  assign w_is_alu  = i_ir[7];
  assign w_alu_cmp = is_cmp(i_ir[2:0]);

  always_comb begin
    o_wr_x       = 1'b0;
    o_x_from_alu = 1'b0;
    o_wr_y       = 1'b0;
    o_y_from_x   = 1'b0;
    o_wr_flag    = 1'b0;
    o_is_jmp     = 1'b0;
    o_is_jf      = 1'b0;
    o_is_hlt     = 1'b0;
    if (w_is_alu) begin
      o_wr_flag    = w_alu_cmp;
      o_wr_x       = !w_alu_cmp;
      o_x_from_alu = 1'b1;
    end else begin
      // NOP and the reserved opcode fall through with nothing enabled.
      case (w_op)
        OP_LDX: o_wr_x = 1'b1;
        OP_LDY: o_wr_y = 1'b1;
        OP_MOV: begin
          o_wr_y     = 1'b1;
          o_y_from_x = 1'b1;
        end
        OP_JMP:  o_is_jmp = 1'b1;
        OP_JF:   o_is_jf  = 1'b1;
        OP_HLT:  o_is_hlt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ula_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequencer
// Purpose  : Control unit for the 4-bit ALU. It fetches 8-bit instructions
//            from a program ROM, owns the X/Y operand registers, issues the
//            ALU op code and writes back the ALU result or the compare flag.
//            Each non-halt instruction takes FETCH, EXEC and WB.
// Ports    : clk, rst    - clock, asynchronous active-high reset
//            start       - begin execution (honoured only in IDLE)
//            pc / instr  - ROM address / ROM data (async read)
//            outx, outy  - X and Y registers to the ALU
//            tula        - registered ALU op code
//            outula      - ALU result; status - ALU compare result
//            flag        - latched compare flag
//            busy        - high in FETCH/EXEC/WB; halted - high in HALT
// Revision : 1.0 - initial release
// ============================================================================
module ula_sequencer #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  input  logic [7:0]        instr,
  output logic [DATA_W-1:0] outx,
  output logic [DATA_W-1:0] outy,
  output logic [2:0]        tula,
  input  logic [DATA_W-1:0] outula,
  input  logic              status,
  output logic              flag,
  output logic              busy,
  output logic              halted
);
  import ula_sequencer_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [DATA_W-1:0]  r_x;
  logic [DATA_W-1:0]  r_y;
  logic [7:0]         r_ir;
  logic               r_flag;
  logic [2:0]         r_tula;

  logic [3:0]         w_imm;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_wr_x;
  logic               w_x_from_alu;
  logic               w_wr_y;
  logic               w_y_from_x;
  logic               w_wr_flag;
  logic               w_is_jmp;
  logic               w_is_jf;
  logic               w_is_hlt;

  assign w_imm    = r_ir[3:0];
  assign w_pc_inc = r_pc + PC_W'(1);

  ula_seq_decode u_decode (
    .i_ir         (r_ir),
    .o_wr_x       (w_wr_x),
    .o_x_from_alu (w_x_from_alu),
    .o_wr_y       (w_wr_y),
    .o_y_from_x   (w_y_from_x),
    .o_wr_flag    (w_wr_flag),
    .o_is_jmp     (w_is_jmp),
    .o_is_jf      (w_is_jf),
    .o_is_hlt     (w_is_hlt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = ST_WB;
      ST_WB:    w_state_nxt = w_is_hlt ? ST_HALT : ST_FETCH;
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. X and Y only move in EXEC, so the ALU sees stable operands
  // throughout the cycle in which its result is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_ir   <= '0;
      r_flag <= 1'b0;
      r_tula <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir <= instr;
          // tula is set up a cycle early so the ALU settles before EXEC.
          if (instr[7]) r_tula <= instr[2:0];
        end
        ST_EXEC: begin
          if (w_wr_x)    r_x    <= w_x_from_alu ? outula : DATA_W'(w_imm);
          if (w_wr_y)    r_y    <= w_y_from_x ? r_x : DATA_W'(w_imm);
          if (w_wr_flag) r_flag <= status;
        end
        ST_WB: begin
          if (w_is_jmp)       r_pc <= PC_W'(w_imm);
          else if (w_is_jf)   r_pc <= r_flag ? PC_W'(w_imm) : w_pc_inc;
          else if (!w_is_hlt) r_pc <= w_pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign pc     = r_pc;
  assign outx   = r_x;
  assign outy   = r_y;
  assign tula   = r_tula;
  assign flag   = r_flag;
  assign busy   = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_WB);
  assign halted = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Control unit that drives the 4-bit ALU. It fetches 8-bit instructions from a 16-entry program ROM and owns the X and Y operand registers.
- It issues the ALU operation code and writes back either the ALU result or the compare status.
- It is the initiator side of the ALU interface: it drives outx, outy and tula, and consumes outula and status.
- It sits between the program ROM and the combinational ALU in the CPU top level.

Parameters:
- PC_W, 4, program-counter width; ROM depth is 2**PC_W.
- DATA_W, 4, operand width; must match the ALU.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins execution from pc=0; honoured only in IDLE.
- pc  output  PC_W  ROM address.
- instr  input  8  ROM data; asynchronous read of address pc.
- outx  output  DATA_W  X register, to ALU operand x.
- outy  output  DATA_W  Y register, to ALU operand y.
- tula  output  3  ALU operation code, registered.
- outula  input  DATA_W  ALU result.
- status  input  1  ALU compare result.
- flag  output  1  latched compare flag.
- busy  output  1  high in FETCH, EXEC and WB.
- halted  output  1  high in HALT.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - pc, outx, outy, ir, flag and tula all 0; busy=0, halted=0.
  - Reset asserted mid-instruction aborts it; no partial writeback.
- Instruction format: ir[7:4] is the opcode, ir[3:0] is the immediate imm.
- Opcodes:
  - 0000 NOP.
  - 0001 LDX: X<=imm.
  - 0010 LDY: Y<=imm.
  - 0011 MOV: Y<=X.
  - 0100 JMP: pc<=imm.
  - 0101 JF: if flag, pc<=imm; else pc+1.
  - 0110 HLT.
  - 0111 reserved; executes as NOP.
  - 1ttt ALU op with tula=ttt.
- States: IDLE, FETCH, EXEC, WB, HALT. Each non-HLT instruction takes exactly 3 cycles (FETCH, EXEC, WB).
- IDLE:
  - start=1 moves to FETCH with pc unchanged (0 after reset).
  - start is ignored in all other states.
- FETCH:
  - ir<=instr.
  - If instr[7]=1, tula<=instr[2:0]; otherwise tula holds its prior value.
  - Go to EXEC.
- EXEC:
  - ALU ops with ttt in {011,100,101}: flag<=status.
  - Other ALU ops (000,001,010,110,111): X<=outula. Result is DATA_W bits, mod-16 wrap, no carry kept.
  - LDX, LDY and MOV write their register in this state.
  - Go to WB.
- WB:
  - JMP: pc<=imm.
  - JF: pc<=imm if flag, else pc+1. Uses the flag value as of this cycle, so a compare immediately before JF is honoured.
  - HLT: pc unchanged; go to HALT.
  - All others: pc<=pc+1, wrapping 15 to 0.
  - Non-HLT instructions go to FETCH.
- HALT: terminal; left only by rst. start is ignored.
- Non-compare instructions leave flag unchanged.
- X and Y change only in EXEC, so operands are stable to the ALU during the cycle in which results are sampled.

Decomposition:
- Shared include file, also used by the assembler/test ROMs, holds:
  - opcode localparams (OP_NOP, OP_LDX, OP_LDY, OP_MOV, OP_JMP, OP_JF, OP_HLT);
  - tula codes (ULA_ADD=000, ULA_SUB=001, ULA_NEG=010, ULA_EQ=011, ULA_GT=100, ULA_LT=101, ULA_AND=110, ULA_XOR=111);
  - state encodings.
- One natural sub-module: ula_seq_decode, a combinational decode of ir into write-enables (wr_x, wr_y, wr_flag, is_jmp, is_jf, is_hlt).
- The ALU itself is instantiated at top level, not inside this block.

Test Plan:
- ROM {LDX 3, LDY 5, ADD (0x80), HLT}, start pulse:
  - X=8 after instruction 3's EXEC;
  - halted=1 at cycle 12 after start;
  - pc=3.
- ROM {LDX 3, LDY 5, SUB (0x81), HLT} -> X=0xE (wrap); flag stays 0.
- ROM {LDX 7, LDY 7, EQ (0x83), JF 6, ..., [6] HLT} -> flag=1; pc jumps to 6; ALU writes to X are suppressed for EQ.
- Same program with LDY 2 -> flag=0; JF falls through to pc=4.
- ROM filled with NOP, one JMP at 15 absent -> pc wraps 15 to 0 and continues; busy stays 1.
- rst asserted during EXEC of an LDX:
  - all outputs return to 0 asynchronously;
  - X is not written;
  - a start pulse afterwards restarts from pc=0.
